// File: rtl/instr_dispatch.sv
// Instruction queue and in-order dual-issue dispatcher feeding the load/store, RAM and arith pipes.
// Optional perf counters (perf_issued, perf_stall) are built when DISPATCH_PERF_CNT_EN is defined.
module instr_dispatch #(
   parameter int unsigned LOG_DEPTH = 4,
   parameter int unsigned LS_MAX    = 7,
   parameter int unsigned LS_CNT_W  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push_we,
   input  logic [1:0]  push_type,
   input  logic [17:0] push_cache_addr,
   input  logic [17:0] push_main_mem_addr,
   input  logic [17:0] push_d_cache_addr,
   input  logic [17:0] push_d_main_mem_addr,
   output logic        queue_full,
   output logic        queue_empty,
   output logic        overflow,
   output logic        ls_valid,
   input  logic        ls_ready,
   output logic [17:0] ls_cache_addr,
   output logic [17:0] ls_d_cache_addr,
   input  logic        ls_done,
   output logic        ram_valid,
   input  logic        ram_ready,
   output logic [17:0] ram_cache_addr,
   output logic [17:0] ram_main_mem_addr,
   output logic [17:0] ram_d_cache_addr,
   output logic [17:0] ram_d_main_mem_addr,
   output logic        arith_valid,
   input  logic        arith_ready
`ifdef DISPATCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_stall
`endif
);

   localparam int unsigned DEPTH = 1 << LOG_DEPTH;
   localparam int unsigned AW    = 18;
   localparam int unsigned CW    = LOG_DEPTH + 1;

   typedef enum logic [1:0] {
      T_LDST  = 2'd0,
      T_RAM   = 2'd1,
      T_ARITH = 2'd2,
      T_LOOP  = 2'd3
   } itype_e;

   typedef struct packed {
      itype_e        itype;
      logic [AW-1:0] cache_addr;
      logic [AW-1:0] main_mem_addr;
      logic [AW-1:0] d_cache_addr;
      logic [AW-1:0] d_main_mem_addr;
   } entry_t;

   entry_t                mem [DEPTH];
   logic [LOG_DEPTH-1:0]  head;
   logic [LOG_DEPTH-1:0]  tail;
   logic [CW-1:0]         count;
   logic [LS_CNT_W-1:0]   ls_outstanding;

   entry_t      s0;
   entry_t      s1;
   logic        v0, v1;
   logic        ls_room, ls_idle;
   logic        elig0, rdy0, issue0;
   logic        elig1, rdy1, cand1, issue1;
   logic        ls_inc;
   logic [1:0]  pops;
   logic        push_ok;

   assign s0          = mem[head];
   assign s1          = mem[head + LOG_DEPTH'(1)];
   assign v0          = (count != '0);
   assign v1          = (count >= CW'(2));
   assign queue_full  = (count == CW'(DEPTH));
   assign queue_empty = (count == '0);
   assign push_ok     = push_we && !queue_full;
   assign ls_room     = (ls_outstanding < LS_CNT_W'(LS_MAX));
   assign ls_idle     = (ls_outstanding == '0);

   // Slot eligibility and issue; slot1 only rides along behind an issuing slot0 of another pipe.
   always_comb begin
      elig0 = 1'b0;
      rdy0  = 1'b0;
      elig1 = 1'b0;
      rdy1  = 1'b0;
      case (s0.itype)
         T_LDST:  begin elig0 = ls_room; rdy0 = ls_ready;    end
         T_RAM:   begin elig0 = ls_idle; rdy0 = ram_ready;   end
         T_ARITH: begin elig0 = 1'b1;    rdy0 = arith_ready; end
         T_LOOP:  begin elig0 = 1'b1;    rdy0 = 1'b1;        end
      endcase
      case (s1.itype)
         T_LDST:  begin elig1 = ls_room;                            rdy1 = ls_ready;    end
         T_RAM:   begin elig1 = ls_idle && (s0.itype != T_LDST);    rdy1 = ram_ready;   end
         T_ARITH: begin elig1 = 1'b1;                               rdy1 = arith_ready; end
         T_LOOP:  begin elig1 = 1'b1;                               rdy1 = 1'b1;        end
      endcase
      issue0 = v0 && elig0 && rdy0;
      cand1  = issue0 && v1 && (s1.itype != s0.itype) && elig1;
      issue1 = cand1 && rdy1;
      ls_inc = (issue0 && s0.itype == T_LDST) || (issue1 && s1.itype == T_LDST);
      pops   = {1'b0, issue0} + {1'b0, issue1};
   end

   // Pipe valid/address steering, slot0 taking priority.
   always_comb begin
      ls_valid            = 1'b0;
      ls_cache_addr       = s0.cache_addr;
      ls_d_cache_addr     = s0.d_cache_addr;
      ram_valid           = 1'b0;
      ram_cache_addr      = s0.cache_addr;
      ram_main_mem_addr   = s0.main_mem_addr;
      ram_d_cache_addr    = s0.d_cache_addr;
      ram_d_main_mem_addr = s0.d_main_mem_addr;
      arith_valid         = 1'b0;
      if (v0 && elig0 && s0.itype == T_LDST) begin
         ls_valid = 1'b1;
      end else if (cand1 && s1.itype == T_LDST) begin
         ls_valid        = 1'b1;
         ls_cache_addr   = s1.cache_addr;
         ls_d_cache_addr = s1.d_cache_addr;
      end
      if (v0 && elig0 && s0.itype == T_RAM) begin
         ram_valid = 1'b1;
      end else if (cand1 && s1.itype == T_RAM) begin
         ram_valid           = 1'b1;
         ram_cache_addr      = s1.cache_addr;
         ram_main_mem_addr   = s1.main_mem_addr;
         ram_d_cache_addr    = s1.d_cache_addr;
         ram_d_main_mem_addr = s1.d_main_mem_addr;
      end
      if ((v0 && elig0 && s0.itype == T_ARITH) || (cand1 && s1.itype == T_ARITH)) begin
         arith_valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[tail] <= '{itype:           itype_e'(push_type),
                        cache_addr:      push_cache_addr,
                        main_mem_addr:   push_main_mem_addr,
                        d_cache_addr:    push_d_cache_addr,
                        d_main_mem_addr: push_d_main_mem_addr};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         ls_outstanding <= '0;
         overflow       <= 1'b0;
      end else begin
         if (push_ok) tail <= tail + LOG_DEPTH'(1);
         head  <= head + LOG_DEPTH'(pops);
         count <= count + CW'(push_ok) - CW'(pops);
         if (push_we && queue_full) overflow <= 1'b1;
         // Done at zero is ignored; issue plus done in one cycle nets to no change.
         if (ls_inc && !ls_done) begin
            ls_outstanding <= ls_outstanding + LS_CNT_W'(1);
         end else if (!ls_inc && ls_done && !ls_idle) begin
            ls_outstanding <= ls_outstanding - LS_CNT_W'(1);
         end
      end
   end

`ifdef DISPATCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         perf_issued <= perf_issued + 32'(pops);
         if (!queue_empty && pops == 2'd0) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed self-checking bench for instr_dispatch (perf ports connected when DISPATCH_PERF_CNT_EN is defined).
module tb_instr_dispatch;

   logic        clk = 1'b0;
   logic        reset;
   logic        push_we;
   logic [1:0]  push_type;
   logic [17:0] push_cache_addr, push_main_mem_addr, push_d_cache_addr, push_d_main_mem_addr;
   logic        queue_full, queue_empty, overflow;
   logic        ls_valid, ls_ready, ls_done;
   logic [17:0] ls_cache_addr, ls_d_cache_addr;
   logic        ram_valid, ram_ready;
   logic [17:0] ram_cache_addr, ram_main_mem_addr, ram_d_cache_addr, ram_d_main_mem_addr;
   logic        arith_valid, arith_ready;
`ifdef DISPATCH_PERF_CNT_EN
   logic [31:0] perf_issued, perf_stall;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   instr_dispatch dut (
      .clk(clk), .reset(reset),
      .push_we(push_we), .push_type(push_type),
      .push_cache_addr(push_cache_addr), .push_main_mem_addr(push_main_mem_addr),
      .push_d_cache_addr(push_d_cache_addr), .push_d_main_mem_addr(push_d_main_mem_addr),
      .queue_full(queue_full), .queue_empty(queue_empty), .overflow(overflow),
      .ls_valid(ls_valid), .ls_ready(ls_ready),
      .ls_cache_addr(ls_cache_addr), .ls_d_cache_addr(ls_d_cache_addr), .ls_done(ls_done),
      .ram_valid(ram_valid), .ram_ready(ram_ready),
      .ram_cache_addr(ram_cache_addr), .ram_main_mem_addr(ram_main_mem_addr),
      .ram_d_cache_addr(ram_d_cache_addr), .ram_d_main_mem_addr(ram_d_main_mem_addr),
      .arith_valid(arith_valid), .arith_ready(arith_ready)
`ifdef DISPATCH_PERF_CNT_EN
      , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] t, input logic [17:0] ca, input logic [17:0] mma);
      push_we              = 1'b1;
      push_type            = t;
      push_cache_addr      = ca;
      push_main_mem_addr   = mma;
      push_d_cache_addr    = 18'h2AAAA;
      push_d_main_mem_addr = 18'h15555;
      step();
      push_we = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0; push_we = 1'b0; push_type = '0;
      push_cache_addr = '0; push_main_mem_addr = '0;
      push_d_cache_addr = '0; push_d_main_mem_addr = '0;
      ls_ready = 1'b0; ls_done = 1'b0; ram_ready = 1'b0; arith_ready = 1'b0;
      do_reset();

      // Reset state
      check("rst_empty", 32'(queue_empty), 32'd1);
      check("rst_full", 32'(queue_full), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_valids", {29'd0, ls_valid, ram_valid, arith_valid}, 32'd0);

      // 1: single ARITH
      arith_ready = 1'b1;
      push(2'd2, 18'h00005, 18'h0);
      check("t1_arith_valid", 32'(arith_valid), 32'd1);
      check("t1_not_empty", 32'(queue_empty), 32'd0);
      step();
      check("t1_empty", 32'(queue_empty), 32'd1);
      check("t1_arith_low", 32'(arith_valid), 32'd0);
      arith_ready = 1'b0;

      // 2: LD/ST + ARITH dual issue
      push(2'd0, 18'h00011, 18'h0);
      push(2'd2, 18'h00022, 18'h0);
      check("t2_count2", 32'(dut.count), 32'd2);
      check("t2_ls_valid_hold", 32'(ls_valid), 32'd1);
      check("t2_no_bypass", 32'(arith_valid), 32'd0);
      ls_ready = 1'b1; arith_ready = 1'b1;
      #1;
      check("t2_ls_valid", 32'(ls_valid), 32'd1);
      check("t2_arith_valid", 32'(arith_valid), 32'd1);
      check("t2_ls_ca", 32'(ls_cache_addr), 32'h11);
      check("t2_ls_dca", 32'(ls_d_cache_addr), 32'h2AAAA);
      step();
      check("t2_count0", 32'(dut.count), 32'd0);
      check("t2_outst1", 32'(dut.ls_outstanding), 32'd1);
      ls_ready = 1'b0; arith_ready = 1'b0;
      ls_done = 1'b1;
      step();
      ls_done = 1'b0;
      check("t2_outst0", 32'(dut.ls_outstanding), 32'd0);

      // 3: RAM barrier behind LD/ST
      push(2'd0, 18'h00033, 18'h0);
      push(2'd1, 18'h00044, 18'h3FFFF);
      check("t3_ram_blk0", 32'(ram_valid), 32'd0);
      ls_ready = 1'b1; ram_ready = 1'b1;
      #1;
      check("t3_ram_blk_same", 32'(ram_valid), 32'd0);
      step();
      ls_ready = 1'b0;
      check("t3_outst1", 32'(dut.ls_outstanding), 32'd1);
      check("t3_ram_blk1", 32'(ram_valid), 32'd0);
      step();
      check("t3_ram_blk2", 32'(ram_valid), 32'd0);
      ls_done = 1'b1;
      #1;
      check("t3_ram_blk_done", 32'(ram_valid), 32'd0);
      step();
      ls_done = 1'b0;
      check("t3_ram_valid", 32'(ram_valid), 32'd1);
      check("t3_ram_mma", 32'(ram_main_mem_addr), 32'h3FFFF);
      check("t3_ram_ca", 32'(ram_cache_addr), 32'h44);
      check("t3_ram_dmma", 32'(ram_d_main_mem_addr), 32'h15555);
      step();
      check("t3_empty", 32'(queue_empty), 32'd1);
      ram_ready = 1'b0;

      // 4: fill, drop on full even with a same-cycle pop, wrap and order
      for (int i = 0; i < 16; i++) push(2'd1, 18'(i), 18'h0);
      check("t4_full", 32'(queue_full), 32'd1);
      check("t4_ovf0", 32'(overflow), 32'd0);
      ram_ready = 1'b1;
      #1;
      check("t4_head0", 32'(ram_cache_addr), 32'd0);
      push(2'd1, 18'h00099, 18'h0);
      check("t4_ovf1", 32'(overflow), 32'd1);
      check("t4_count15", 32'(dut.count), 32'd15);
      for (int i = 1; i < 16; i++) begin
         check($sformatf("t4_order%0d", i), {13'd0, ram_valid, ram_cache_addr}, {13'd0, 1'b1, 18'(i)});
         step();
      end
      check("t4_drained", 32'(queue_empty), 32'd1);
      check("t4_ovf_sticky", 32'(overflow), 32'd1);
      ram_ready = 1'b0;

      // 5: outstanding load/store limit
      for (int i = 0; i < 9; i++) push(2'd0, 18'h00100 + 18'(i), 18'h0);
      ls_ready = 1'b1;
      #1;
      for (int i = 0; i < 7; i++) begin
         check($sformatf("t5_ls%0d", i), {13'd0, ls_valid, ls_cache_addr}, {13'd0, 1'b1, 18'h00100 + 18'(i)});
         step();
      end
      check("t5_limit_valid", 32'(ls_valid), 32'd0);
      check("t5_outst7", 32'(dut.ls_outstanding), 32'd7);
      step();
      check("t5_still_held", 32'(ls_valid), 32'd0);
      ls_done = 1'b1;
      step();
      ls_done = 1'b0;
      check("t5_outst6", 32'(dut.ls_outstanding), 32'd6);
      check("t5_ls7", {13'd0, ls_valid, ls_cache_addr}, {13'd0, 1'b1, 18'h00107});
      ls_done = 1'b1;
      step();
      ls_done = 1'b0;
      check("t5_net_zero", 32'(dut.ls_outstanding), 32'd6);
      check("t5_ls8", {13'd0, ls_valid, ls_cache_addr}, {13'd0, 1'b1, 18'h00108});
      step();
      check("t5_outst7b", 32'(dut.ls_outstanding), 32'd7);
      check("t5_empty", 32'(queue_empty), 32'd1);
      ls_ready = 1'b0;
      ls_done = 1'b1;
      for (int i = 0; i < 9; i++) step();
      ls_done = 1'b0;
      check("t5_sat0", 32'(dut.ls_outstanding), 32'd0);

      // 6: LOOP self-retires, ARITH rides in slot1
      push(2'd3, 18'h00055, 18'h0);
      push(2'd2, 18'h00066, 18'h0);
      arith_ready = 1'b1;
      #1;
      check("t6_arith_slot1", 32'(arith_valid), 32'd1);
      check("t6_other_valids", {30'd0, ls_valid, ram_valid}, 32'd0);
      step();
      check("t6_empty", 32'(queue_empty), 32'd1);
      arith_ready = 1'b0;

      // Mid-operation reset with 5 entries queued
      push(2'd1, 18'h00001, 18'h0);
      push(2'd0, 18'h00002, 18'h0);
      push(2'd2, 18'h00003, 18'h0);
      push(2'd1, 18'h00004, 18'h0);
      push(2'd3, 18'h00005, 18'h0);
      check("t6_count5", 32'(dut.count), 32'd5);
      check("t6_ram_pre", 32'(ram_valid), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6_rst_empty", 32'(queue_empty), 32'd1);
      check("t6_rst_valids", {29'd0, ls_valid, ram_valid, arith_valid}, 32'd0);
      check("t6_rst_ovf", 32'(overflow), 32'd0);
      check("t6_rst_outst", 32'(dut.ls_outstanding), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
